// File: rtl/database_stage_reader_if.sv
// Request, database read port and classifier word stream of database_stage_reader.
// Handshake: a word transfers on each rising clk edge with o_valid && i_ready; o_valid, o_data and tags hold until then.
interface database_stage_reader_if #(
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH_16 = 16
);
   logic                     i_start;
   logic [1:0]               i_stage;
   logic                     o_busy;
   logic                     o_mem_ren;
   logic [ADDR_WIDTH-1:0]    o_mem_addr;
   logic [DATA_WIDTH_16-1:0] i_mem_data;
   logic                     o_valid;
   logic                     i_ready;
   logic [DATA_WIDTH_16-1:0] o_data;
   logic [4:0]               o_param_index;
   logic [7:0]               o_classifier_index;
   logic                     o_is_threshold;
   logic                     o_last;
   logic                     o_done;
   logic                     o_error;
   logic [2:0]               dbg_state;

   modport master (
      input  i_start, i_stage, i_mem_data, i_ready,
      output o_busy, o_mem_ren, o_mem_addr, o_valid, o_data, o_param_index,
             o_classifier_index, o_is_threshold, o_last, o_done, o_error, dbg_state
   );

   modport slave (
      output i_start, i_stage, i_mem_data, i_ready,
      input  o_busy, o_mem_ren, o_mem_addr, o_valid, o_data, o_param_index,
             o_classifier_index, o_is_threshold, o_last, o_done, o_error, dbg_state
   );
endinterface

// File: rtl/database_stage_reader.sv
// Streams one stage of the classifier database (params then thresholds) from a 1-cycle read port.
// Optional abort input enabled by defining DATABASE_READER_ABORT_EN.
module database_stage_reader #(
   parameter int ADDR_WIDTH               = 10,
   parameter int DATA_WIDTH_16            = 16,
   parameter int NUM_PARAM_PER_CLASSIFIER = 19,
   parameter int NUM_STAGE_THRESHOLD      = 3,
   parameter int NUM_CLASSIFIERS_STAGE_1  = 10,
   parameter int NUM_CLASSIFIERS_STAGE_2  = 10,
   parameter int NUM_CLASSIFIERS_STAGE_3  = 10
) (
   input  logic                    clk,
   input  logic                    reset,
`ifdef DATABASE_READER_ABORT_EN
   input  logic                    i_abort,
`endif
   database_stage_reader_if.master dbr
);
   localparam int SIZE_1 = NUM_CLASSIFIERS_STAGE_1 * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
   localparam int SIZE_2 = NUM_CLASSIFIERS_STAGE_2 * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
   localparam int SIZE_3 = NUM_CLASSIFIERS_STAGE_3 * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
   localparam int TOTAL  = SIZE_1 + SIZE_2 + SIZE_3;
   localparam int CW     = ADDR_WIDTH + 1;

   localparam logic [ADDR_WIDTH-1:0] BASE_1     = '0;
   localparam logic [ADDR_WIDTH-1:0] BASE_2     = ADDR_WIDTH'(SIZE_1);
   localparam logic [ADDR_WIDTH-1:0] BASE_3     = ADDR_WIDTH'(SIZE_1 + SIZE_2);
   localparam logic [4:0]            PARAM_LAST = 5'(NUM_PARAM_PER_CLASSIFIER - 1);
   localparam logic [CW-1:0]         ONE_C      = CW'(1);

   if (TOTAL > (1 << ADDR_WIDTH)) begin : g_size_check
      $error("database_stage_reader: stage regions exceed the address space");
   end

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DONE} state_e;

   state_e                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    base_q, base_d;
   logic [CW-1:0]            size_q, size_d;
   logic [CW-1:0]            count_q, count_d;
   logic [7:0]               ncls_q, ncls_d;
   logic [7:0]               cls_q, cls_d;
   logic [4:0]               param_q, param_d;
   logic                     thr_q, thr_d;

   logic                     busy_q, busy_d;
   logic                     ren_q, ren_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic                     valid_q, valid_d;
   logic [DATA_WIDTH_16-1:0] data_q, data_d;
   logic [4:0]               param_out_q, param_out_d;
   logic [7:0]               cls_out_q, cls_out_d;
   logic                     thr_out_q, thr_out_d;
   logic                     last_q, last_d;
   logic                     done_q, done_d;
   logic                     error_q, error_d;

   logic                     handshake;
   logic                     abort;
   logic [ADDR_WIDTH-1:0]    sel_base;
   logic [CW-1:0]            sel_size;
   logic [7:0]               sel_ncls;

   assign handshake = valid_q && dbr.i_ready;

`ifdef DATABASE_READER_ABORT_EN
   assign abort = i_abort && (state_q != S_IDLE);
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      sel_base = BASE_1;
      sel_size = CW'(SIZE_1);
      sel_ncls = 8'(NUM_CLASSIFIERS_STAGE_1);
      case (dbr.i_stage)
         2'd1: begin
            sel_base = BASE_2;
            sel_size = CW'(SIZE_2);
            sel_ncls = 8'(NUM_CLASSIFIERS_STAGE_2);
         end
         2'd2: begin
            sel_base = BASE_3;
            sel_size = CW'(SIZE_3);
            sel_ncls = 8'(NUM_CLASSIFIERS_STAGE_3);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      size_d      = size_q;
      count_d     = count_q;
      ncls_d      = ncls_q;
      cls_d       = cls_q;
      param_d     = param_q;
      thr_d       = thr_q;
      busy_d      = busy_q;
      ren_d       = 1'b0;
      addr_d      = addr_q;
      valid_d     = valid_q;
      data_d      = data_q;
      param_out_d = param_out_q;
      cls_out_d   = cls_out_q;
      thr_out_d   = thr_out_q;
      last_d      = last_q;
      done_d      = 1'b0;
      error_d     = 1'b0;

      if (abort) begin
         // A word offered in the abort cycle is treated as not consumed.
         state_d = S_IDLE;
         valid_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (dbr.i_start) begin
                  if (dbr.i_stage == 2'd3) begin
                     error_d = 1'b1;
                  end else begin
                     base_d  = sel_base;
                     size_d  = sel_size;
                     ncls_d  = sel_ncls;
                     count_d = '0;
                     cls_d   = '0;
                     param_d = '0;
                     thr_d   = 1'b0;
                     busy_d  = 1'b1;
                     ren_d   = 1'b1;
                     addr_d  = sel_base;
                     state_d = S_REQ;
                  end
               end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
               data_d      = dbr.i_mem_data;
               param_out_d = param_q;
               cls_out_d   = cls_q;
               thr_out_d   = thr_q;
               last_d      = (count_q == size_q - ONE_C);
               valid_d     = 1'b1;
               state_d     = S_OUT;
            end
            S_OUT: begin
               if (handshake) begin
                  valid_d = 1'b0;
                  count_d = count_q + ONE_C;
                  if (thr_q) begin
                     param_d = param_q + 5'd1;
                  end else if (param_q == PARAM_LAST) begin
                     // Classifier index stays on the last classifier through the thresholds.
                     param_d = '0;
                     if (cls_q == ncls_q - 8'd1) thr_d = 1'b1;
                     else                        cls_d = cls_q + 8'd1;
                  end else begin
                     param_d = param_q + 5'd1;
                  end
                  if (last_q) begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     ren_d   = 1'b1;
                     addr_d  = base_q + count_d[ADDR_WIDTH-1:0];
                     state_d = S_REQ;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         size_q      <= '0;
         count_q     <= '0;
         ncls_q      <= '0;
         cls_q       <= '0;
         param_q     <= '0;
         thr_q       <= 1'b0;
         busy_q      <= 1'b0;
         ren_q       <= 1'b0;
         addr_q      <= '0;
         valid_q     <= 1'b0;
         data_q      <= '0;
         param_out_q <= '0;
         cls_out_q   <= '0;
         thr_out_q   <= 1'b0;
         last_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         size_q      <= size_d;
         count_q     <= count_d;
         ncls_q      <= ncls_d;
         cls_q       <= cls_d;
         param_q     <= param_d;
         thr_q       <= thr_d;
         busy_q      <= busy_d;
         ren_q       <= ren_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         data_q      <= data_d;
         param_out_q <= param_out_d;
         cls_out_q   <= cls_out_d;
         thr_out_q   <= thr_out_d;
         last_q      <= last_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign dbr.o_busy             = busy_q;
   assign dbr.o_mem_ren          = ren_q;
   assign dbr.o_mem_addr         = addr_q;
   assign dbr.o_valid            = valid_q;
   assign dbr.o_data             = data_q;
   assign dbr.o_param_index      = param_out_q;
   assign dbr.o_classifier_index = cls_out_q;
   assign dbr.o_is_threshold     = thr_out_q;
   assign dbr.o_last             = last_q;
   assign dbr.o_done             = done_q;
   assign dbr.o_error            = error_q;
   assign dbr.dbg_state          = state_q;
endmodule

// File: tb/tb_database_stage_reader.sv
// Directed-sequence bench for database_stage_reader with random memory contents and random ready.
// Expected words come from a per-stage layout model; abort steps are built when DATABASE_READER_ABORT_EN is defined.
module tb_database_stage_reader;
   localparam int NP        = 19;
   localparam int NT        = 3;
   localparam int EW        = 31;
   localparam int CUT_RESET = 1;
   localparam int CUT_ABORT = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
`ifdef DATABASE_READER_ABORT_EN
   logic i_abort = 1'b0;
`endif

   database_stage_reader_if dbr ();

   database_stage_reader dut (
      .clk     (clk),
      .reset   (reset),
`ifdef DATABASE_READER_ABORT_EN
      .i_abort (i_abort),
`endif
      .dbr     (dbr)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- memory model ----------------
   logic [15:0] mem [0:1023];

   always @(posedge clk) begin
      if (dbr.o_mem_ren) dbr.i_mem_data <= mem[dbr.o_mem_addr];
      else               dbr.i_mem_data <= 16'($urandom);
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int            addr_q[$];
   int            errors = 0;
   int            checks = 0;
   int            ncls_tab[3] = '{10, 10, 10};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int stage_size(input int stage);
      return ncls_tab[stage] * NP + NT;
   endfunction

   function automatic int stage_base(input int stage);
      int b = 0;
      for (int s = 0; s < stage; s++) b += stage_size(s);
      return b;
   endfunction

   function automatic logic [EW-1:0] model_word(input int stage, input int k);
      int   ncls, c, p;
      logic t;
      ncls = ncls_tab[stage];
      if (k < ncls * NP) begin
         c = k / NP;
         p = k % NP;
         t = 1'b0;
      end else begin
         c = ncls - 1;
         p = k - ncls * NP;
         t = 1'b1;
      end
      return {mem[stage_base(stage) + k], 5'(p), 8'(c), t, (k == stage_size(stage) - 1)};
   endfunction

   function automatic logic [EW-1:0] word_obs();
      return {dbr.o_data, dbr.o_param_index, dbr.o_classifier_index, dbr.o_is_threshold, dbr.o_last};
   endfunction

   function automatic logic [45:0] all_outs();
      return {dbr.o_busy, dbr.o_mem_ren, dbr.o_mem_addr, dbr.o_valid, dbr.o_data, dbr.o_param_index,
              dbr.o_classifier_index, dbr.o_is_threshold, dbr.o_last, dbr.o_done, dbr.o_error};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply_cut(input int kind);
      int late_done, late_ren;
      dbr.i_ready = 1'b1;
      if (kind == CUT_RESET) reset = 1'b1;
`ifdef DATABASE_READER_ABORT_EN
      if (kind == CUT_ABORT) i_abort = 1'b1;
`endif
      @(negedge clk);
      reset = 1'b0;
`ifdef DATABASE_READER_ABORT_EN
      i_abort = 1'b0;
`endif
      if (kind == CUT_RESET) check("outputs_after_reset", all_outs(), 0);
`ifdef DATABASE_READER_ABORT_EN
      else check("abort_valid_busy_done", {dbr.o_valid, dbr.o_busy, dbr.o_done}, 3'b000);
`endif
      late_done = 0;
      late_ren  = 0;
      repeat (8) begin
         @(negedge clk);
         late_done += int'(dbr.o_done);
         late_ren  += int'(dbr.o_mem_ren);
      end
      check("no_done_after_cut", late_done, 0);
      check("no_read_after_cut", late_ren, 0);
      dbr.i_ready = 1'b0;
   endtask

   task automatic run_stage(input int stage, input int bp_word, input int bp_len, input bit rand_bp,
                            input int cut_word, input int cut_kind, input int dup_cyc);
      int            size, cyc, words, reads, done_cnt, err_cnt, bad_ren, stall, prev_hs, budget;
      bit            finished, holding, ready;
      logic [EW-1:0] held;
      size = stage_size(stage);
      exp_q.delete();
      addr_q.delete();
      for (int k = 0; k < size; k++) begin
         exp_q.push_back(model_word(stage, k));
         addr_q.push_back(stage_base(stage) + k);
      end
      cyc = 0; words = 0; reads = 0; done_cnt = 0; err_cnt = 0; bad_ren = 0; stall = 0; prev_hs = 0;
      finished = 1'b0; holding = 1'b0; held = '0;
      budget = rand_bp ? size * 20 + 100 : size * 3 + 50;
      @(negedge clk);
      dbr.i_start = 1'b1;
      dbr.i_stage = 2'(stage);
      while (!finished && cyc < budget) begin
         @(negedge clk);
         cyc++;
         dbr.i_start = (cyc == dup_cyc);
         if (cyc == dup_cyc) dbr.i_stage = 2'($urandom_range(0, 3));
         if (cyc == 1) check("busy_after_start", dbr.o_busy, 1);
         if (dbr.o_error) err_cnt++;
         if (dbr.o_mem_ren && dbr.o_valid) bad_ren++;
         if (dbr.o_mem_ren) begin
            reads++;
            if (addr_q.size() > 0) check("read_addr", dbr.o_mem_addr, addr_q.pop_front());
         end
         if (dbr.o_done) begin
            done_cnt++;
            check("done_after_last_handshake", cyc - prev_hs, 1);
            check("busy_at_done", dbr.o_busy, 0);
            finished = 1'b1;
         end
         ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (dbr.o_valid) begin
            if (words == 0 && !holding) check("first_valid_latency", cyc, 3);
            if (holding) check("held_word", word_obs(), held);
            if (words == bp_word && stall < bp_len) begin
               ready = 1'b0;
               stall++;
            end
            if (words == cut_word) begin
               check("word_at_cut", word_obs(), exp_q[0]);
               apply_cut(cut_kind);
               return;
            end
            if (ready) begin
               if (!rand_bp && words > 0)
                  check("word_spacing", cyc - prev_hs, (words == bp_word) ? 3 + bp_len : 3);
               check("word", word_obs(), (exp_q.size() > 0) ? exp_q.pop_front() : {EW{1'bx}});
               prev_hs = cyc;
               words++;
               holding = 1'b0;
            end else if (!holding) begin
               holding = 1'b1;
               held    = word_obs();
            end
         end
         dbr.i_ready = dbr.o_valid ? ready : 1'($urandom);
      end
      dbr.i_start = 1'b0;
      check("stream_completed", finished, 1);
      check("words_streamed", words, size);
      check("reads_issued", reads, size);
      check("no_error_while_busy", err_cnt, 0);
      check("no_read_while_valid", bad_ren, 0);
      repeat (3) begin
         @(negedge clk);
         dbr.i_ready = 1'b0;
         if (dbr.o_done) done_cnt++;
      end
      check("done_pulses", done_cnt, 1);
      check("busy_after_done", dbr.o_busy, 0);
   endtask

   task automatic illegal_stage();
      int err_cnt, ren_cnt, busy_cnt;
      @(negedge clk);
      dbr.i_start = 1'b1;
      dbr.i_stage = 2'd3;
      @(negedge clk);
      dbr.i_start = 1'b0;
      check("error_pulse", dbr.o_error, 1);
      err_cnt = 1; ren_cnt = 0; busy_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         err_cnt  += int'(dbr.o_error);
         ren_cnt  += int'(dbr.o_mem_ren);
         busy_cnt += int'(dbr.o_busy);
      end
      check("error_pulse_count", err_cnt, 1);
      check("illegal_no_reads", ren_cnt, 0);
      check("illegal_no_busy", busy_cnt, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      dbr.i_start = 1'b0;
      dbr.i_stage = 2'd0;
      dbr.i_ready = 1'b0;
      for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_outputs", all_outs(), 0);

      run_stage(0, -1, 0, 1'b0, -1, 0, 40);
      run_stage(2, 7, 5, 1'b0, -1, 0, 0);
      illegal_stage();
      run_stage(1, -1, 0, 1'b1, -1, 0, 100);
      run_stage(0, -1, 0, 1'b0, 50, CUT_RESET, 0);
      run_stage(1, -1, 0, 1'b0, -1, 0, 0);
`ifdef DATABASE_READER_ABORT_EN
      run_stage(1, -1, 0, 1'b0, 20, CUT_ABORT, 0);
      run_stage(1, -1, 0, 1'b0, -1, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/database_stage_reader.md
Name: database_stage_reader

Overview:
- Read-side counterpart of the database loader.
- On request, walks one stage's region of the loaded classifier database through a 1-cycle-latency read port.
- Streams every word (19 params per classifier, then 3 stage thresholds) to the classification engine over a valid/ready handshake, tagged with position.
- Sits between the database memory and the stage evaluator.

Parameters:
- ADDR_WIDTH, 10, database read address width.
- DATA_WIDTH_16, 16, database word width.
- NUM_PARAM_PER_CLASSIFIER, 19, words per classifier record.
- NUM_STAGE_THRESHOLD, 3, threshold words at the end of each stage.
- NUM_CLASSIFIERS_STAGE_1, 10, classifiers in stage 1.
- NUM_CLASSIFIERS_STAGE_2, 10, classifiers in stage 2.
- NUM_CLASSIFIERS_STAGE_3, 10, classifiers in stage 3.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to stream a stage.
- i_stage  in  2  stage select: 0, 1, 2 = stages 1..3; 3 is illegal.
- o_busy  out  1  high from accepted start until o_done.
- o_mem_ren  out  1  database read enable.
- o_mem_addr  out  ADDR_WIDTH  database read address.
- i_mem_data  in  DATA_WIDTH_16  read data, valid one cycle after o_mem_ren.
- o_valid  out  1  output word valid.
- i_ready  in  1  consumer accepts word.
- o_data  out  DATA_WIDTH_16  streamed word.
- o_param_index  out  5  param index within classifier (0..18), or threshold index (0..2).
- o_classifier_index  out  8  classifier index within stage.
- o_is_threshold  out  1  word is a stage threshold.
- o_last  out  1  final word of the stage.
- o_done  out  1  one-cycle pulse after final handshake.
- o_error  out  1  one-cycle pulse on illegal i_stage with i_start.

Behaviour:
- Derived sizes:
  - SIZE_STAGE_n = NUM_CLASSIFIERS_STAGE_n*NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD.
  - Stage bases: 0, SIZE_STAGE_1, SIZE_STAGE_1+SIZE_STAGE_2.
  - With defaults: 193 words per stage; bases 0, 193, 386.
- Reset:
  - FSM goes to IDLE.
  - All outputs go to 0, including o_mem_addr and o_data.
  - All counters clear.
  - Reset in any state aborts the stream at that edge. No o_done.
- FSM states: IDLE, REQ, WAIT, OUT, DONE.
- IDLE:
  - i_start with i_stage<3: latch base and size, clear counters, o_busy=1, go to REQ.
  - i_start with i_stage==3: o_error=1 next cycle, stay in IDLE.
- REQ:
  - o_mem_ren=1 for one cycle, o_mem_addr = base + word_count.
  - Go to WAIT.
- WAIT:
  - Register i_mem_data into o_data.
  - Register tags from counters.
  - Set o_valid=1, go to OUT.
- OUT:
  - o_valid and o_data are held stable until i_ready.
  - On handshake (o_valid && i_ready), o_valid drops next cycle and counters advance.
  - Param index wraps 18→0 and increments the classifier index.
  - After the last classifier, the tags switch to threshold mode: o_is_threshold=1, o_param_index=0..2.
  - o_classifier_index holds NUM_CLASSIFIERS-1 during thresholds.
  - If the word was o_last, go to DONE; otherwise go to REQ.
- DONE:
  - o_done=1 for one cycle, o_busy=0.
  - Go to IDLE.
- Throughput: one word per 3 cycles with i_ready held high.
- First-word latency: start→REQ→WAIT→OUT, so o_valid rises 3 cycles after the i_start edge.
- i_start while busy (any state other than IDLE): ignored, no error.
- i_ready low while o_valid=0: no effect.
- o_last=1 only on the final threshold word (word_count == SIZE-1).
- o_mem_addr holds its last value when o_mem_ren=0.
- Address arithmetic is ADDR_WIDTH wide. Total size must be ≤ 2^ADDR_WIDTH; this is checked by an elaboration-time assertion.

Optional Feature:
- Macro: DATABASE_READER_ABORT_EN.
- Defined:
  - Adds port i_abort (in, 1).
  - i_abort high in any non-IDLE state: next edge enters IDLE, o_valid=0, o_busy=0, no o_done.
  - i_abort has priority over a simultaneous handshake; the handshake word counts as not consumed.
  - i_abort in IDLE is ignored.
- Not defined: no port, no abort logic.

Test Plan:
- Reset then i_start with i_stage=0, i_ready=1:
  - Addresses 0..192 issued in order.
  - 193 words out, 3 cycles apart.
  - Word 19 tagged classifier 1, param 0.
  - Words 190..192 tagged o_is_threshold=1, param 0..2.
  - o_last on word 192.
  - o_done one cycle after its handshake.
- i_stage=2:
  - First o_mem_addr=386, last =578.
  - o_done pulses once; o_busy low afterwards.
- Backpressure: i_ready low 5 cycles at word 7:
  - o_valid and o_data held constant.
  - No new o_mem_ren.
  - Resumes with word 8 after ready.
- i_start with i_stage=3: o_error pulses once, o_busy stays 0, no memory reads. Second i_start mid-stream: ignored.
- reset asserted mid-stream at word 50:
  - All outputs 0 next cycle, no o_done.
  - A following i_start with i_stage=1 begins cleanly at address 193.
- With DATABASE_READER_ABORT_EN, i_abort at word 20 together with i_ready:
  - IDLE next cycle, no o_done.
  - A restart re-streams from the stage base.
